fir_decim_filter: RTL and testbench

Parametrised decimating FIR low-pass for the FMCW receive chain. It sits directly after the mixer and consumes the signed beat signal (mix_data). The filter is time-multiplexed, using one multiply-accumulate per clock. Coefficients are loadable at run time, and the block emits one filtered sample per DECIM accepted inputs, with a ready/valid handshake and rounding/saturation to the output width.

---
 rtl/fir_decim_filter.sv | 220 ++++++++++++++++++++++
 tb/tb_fir_decim_filter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_filter.sv
`default_nettype none
// ============================================================================
// Module      : fir_decim_filter
// Description : Time-multiplexed decimating FIR low-pass with run-time
//               loadable coefficients, one MAC per clock, ready/valid output
//               handshake, round-half-up and saturation to the sample width.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decim_filter #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 32,
  parameter int DECIM      = 4,
  parameter int OUT_SHIFT  = COEF_WIDTH - 1,
  parameter int ACC_WIDTH  = WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic signed [WIDTH-1:0]      mix_data,
  output logic                         ready,
  output logic signed [WIDTH-1:0]      fir_data,
  output logic                         valid,
  output logic                         ovf,
  input  logic                         coef_we,
  input  logic [$clog2(TAPS)-1:0]      coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wdata,
  output logic                         coef_err
);

  // Widths: tap address, tap counter (needs to reach TAPS for the drain
  // step), phase counter, product, and accumulator plus one rounding bit.
  localparam int AW  = $clog2(TAPS);
  localparam int KW  = $clog2(TAPS + 1);
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PRW = WIDTH + COEF_WIDTH;
  localparam int SW  = ACC_WIDTH + 1;

  localparam logic [AW-1:0] c_last_tap   = AW'(TAPS - 1);
  localparam logic [KW-1:0] c_k_end      = KW'(TAPS);
  localparam logic [PW-1:0] c_phase_last = PW'(DECIM - 1);

  localparam logic signed [SW-1:0] c_out_max =
    $signed({{(SW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}});
  localparam logic signed [SW-1:0] c_out_min =
    $signed({{(SW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [WIDTH-1:0]      r_hist [TAPS];
  logic signed [COEF_WIDTH-1:0] r_coef [TAPS];

  logic [AW-1:0]               r_head;
  logic [AW-1:0]               w_head_nxt;
  logic [AW-1:0]               r_rd_ptr;
  logic [PW-1:0]               r_phase;
  logic [KW-1:0]               r_k;
  logic [AW-1:0]               w_k_idx;
  logic signed [PRW-1:0]       w_prod;
  logic signed [PRW-1:0]       r_prod;
  logic signed [ACC_WIDTH-1:0] r_acc;

  logic                        w_idle;
  logic                        w_accept;
  logic                        w_trigger;
  logic                        w_addr_ok;
  logic                        w_coef_wr;

  logic signed [SW-1:0]        w_acc_ext;
  logic signed [SW-1:0]        w_rounded;
  logic signed [SW-1:0]        w_shifted;
  logic signed [WIDTH-1:0]     w_sat;

  assign w_idle     = (r_state == S_IDLE);
  assign w_accept   = ena && w_idle;
  assign w_trigger  = w_accept && (r_phase == c_phase_last);
  assign w_coef_wr  = coef_we && w_idle && w_addr_ok;

  // The newest sample lives at r_head; x[k] sits k slots behind it.
  assign w_head_nxt = (r_head == c_last_tap) ? '0 : r_head + 1'b1;

  // Addresses past the last tap can only occur when TAPS is not a power of 2.
  generate
    if ((1 << AW) == TAPS) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_check
      assign w_addr_ok = ({1'b0, coef_addr} < (AW + 1)'(TAPS));
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and ready decode. MAC runs k = 0..TAPS: the final step issues
  // no product and lets the accumulator absorb the last registered one.
  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (w_trigger) w_state_nxt = S_MAC;
      end
      S_MAC: begin
        if (r_k == c_k_end) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Circular history write and decimation phase tracking on accepted samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_phase <= '0;
      for (int i = 0; i < TAPS; i++) r_hist[i] <= '0;
    end else if (w_accept) begin
      r_hist[w_head_nxt] <= mix_data;
      r_head             <= w_head_nxt;
      r_phase            <= (r_phase == c_phase_last) ? '0 : r_phase + 1'b1;
    end
  end

  // Coefficient bank; writes only land while idle and in range
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[coef_addr] <= coef_wdata;
    end
  end

  // Product of the current tap; zero on the drain step past the last tap
  always_comb begin
    w_k_idx = '0;
    w_prod  = '0;
    if (r_k < c_k_end) begin
      w_k_idx = r_k[AW-1:0];
      w_prod  = PRW'(r_coef[w_k_idx]) * PRW'(r_hist[r_rd_ptr]);
    end
  end

  // Multiply-accumulate pipeline: register product, add the previous one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_rd_ptr <= '0;
      r_prod   <= '0;
      r_acc    <= '0;
    end else if (w_trigger) begin
      r_k      <= '0;
      r_rd_ptr <= w_head_nxt;
      r_prod   <= '0;
      r_acc    <= '0;
    end else if (r_state == S_MAC) begin
      r_k      <= r_k + 1'b1;
      r_rd_ptr <= (r_rd_ptr == '0) ? c_last_tap : r_rd_ptr - 1'b1;
      r_prod   <= w_prod;
      r_acc    <= r_acc + ACC_WIDTH'(r_prod);
    end
  end

  // Round half-up before the arithmetic shift; no rounding term for shift 0
  assign w_acc_ext = SW'(r_acc);
  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic [SW-1:0] c_half = SW'(1) << (OUT_SHIFT - 1);
      assign w_rounded = w_acc_ext + $signed(c_half);
    end else begin : g_no_round
      assign w_rounded = w_acc_ext;
    end
  endgenerate
  assign w_shifted = w_rounded >>> OUT_SHIFT;

  // Clamp the shifted sum into the output range
  always_comb begin
    w_sat = WIDTH'(w_shifted);
    if (w_shifted > c_out_max)      w_sat = WIDTH'(c_out_max);
    else if (w_shifted < c_out_min) w_sat = WIDTH'(c_out_min);
  end

  // Output register: sample held between strobes, strobe leaves OUT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fir_data <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= (r_state == S_OUT);
      if (r_state == S_OUT) fir_data <= w_sat;
    end
  end

  // One-cycle error pulses for dropped samples and dropped coefficient writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      coef_err <= 1'b0;
    end else begin
      ovf      <= ena && !w_idle;
      coef_err <= coef_we && (!w_idle || !w_addr_ok);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_decim_filter
// Description : Self-checking bench for fir_decim_filter with a behavioural
//               reference (sample queue, coefficient array, plain arithmetic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_decim_filter;

  localparam int WIDTH      = 16;
  localparam int COEF_WIDTH = 16;
  localparam int TAPS       = 32;
  localparam int DECIM      = 4;
  localparam int OUT_SHIFT  = COEF_WIDTH - 1;
  localparam int AW         = $clog2(TAPS);

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ena;
  logic [WIDTH-1:0]      mix_data;
  logic                  ready;
  logic [WIDTH-1:0]      fir_data;
  logic                  valid;
  logic                  ovf;
  logic                  coef_we;
  logic [AW-1:0]         coef_addr;
  logic [COEF_WIDTH-1:0] coef_wdata;
  logic                  coef_err;

  always #5 clk = ~clk;

  fir_decim_filter #(
    .WIDTH(WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS),
    .DECIM(DECIM), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mix_data(mix_data),
    .ready(ready), .fir_data(fir_data), .valid(valid), .ovf(ovf),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference state: newest sample at the front of the queue
  longint m_hist[$];
  longint m_coef[TAPS];
  int     m_phase  = 0;
  int     busy_end = 0;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               at;
  } exp_t;
  exp_t exp_q[$];

  logic [WIDTH-1:0] last_out = '0;
  logic [WIDTH-1:0] obs_q[$];
  int ovf_seen   = 0;
  int cerr_seen  = 0;
  int valid_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] golden();
    longint s;
    longint hi;
    longint lo;
    s  = 0;
    hi = (longint'(1) << (WIDTH - 1)) - 1;
    lo = -(longint'(1) << (WIDTH - 1));
    for (int k = 0; k < m_hist.size(); k++) s += m_coef[k] * m_hist[k];
    if (OUT_SHIFT > 0) s = s + (longint'(1) << (OUT_SHIFT - 1));
    s = s >>> OUT_SHIFT;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return WIDTH'(s);
  endfunction

  // Advance one clock: update the reference from the inputs about to be
  // sampled, then compare every output just after the edge.
  task automatic step();
    bit   m_ready;
    bit   nxt_ovf;
    bit   nxt_cerr;
    bit   exp_valid;
    logic [WIDTH-1:0] exp_data;
    int   e;
    exp_t ent;
    e        = cyc + 1;
    nxt_ovf  = 0;
    nxt_cerr = 0;
    if (!rst_n) begin
      m_hist.delete();
      for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
      m_phase  = 0;
      busy_end = 0;
      exp_q.delete();
      last_out = '0;
    end else begin
      m_ready = (cyc >= busy_end);
      if (coef_we) begin
        if (m_ready && int'(coef_addr) < TAPS) m_coef[coef_addr] = longint'($signed(coef_wdata));
        else nxt_cerr = 1;
      end
      if (ena) begin
        if (m_ready) begin
          m_hist.push_front(longint'($signed(mix_data)));
          if (m_hist.size() > TAPS) void'(m_hist.pop_back());
          if (m_phase == DECIM - 1) begin
            m_phase  = 0;
            ent.data = golden();
            ent.at   = e + TAPS + 2;
            exp_q.push_back(ent);
            busy_end = e + TAPS + 2;
          end else begin
            m_phase++;
          end
        end else begin
          nxt_ovf = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc = e;
    exp_valid = (exp_q.size() > 0) && (exp_q[0].at == cyc);
    exp_data  = exp_valid ? exp_q[0].data : last_out;
    check("ready",    {31'd0, ready},    {31'd0, (cyc >= busy_end)});
    check("valid",    {31'd0, valid},    {31'd0, exp_valid});
    check("fir_data", {16'd0, fir_data}, {16'd0, exp_data});
    check("ovf",      {31'd0, ovf},      {31'd0, nxt_ovf});
    check("coef_err", {31'd0, coef_err}, {31'd0, nxt_cerr});
    if (exp_valid) begin
      last_out = exp_data;
      void'(exp_q.pop_front());
    end
    if (valid === 1'b1) begin
      obs_q.push_back(fir_data);
      valid_seen++;
    end
    if (ovf === 1'b1)      ovf_seen++;
    if (coef_err === 1'b1) cerr_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 4 * TAPS && cyc < busy_end; i++) step();
  endtask

  task automatic push_sample(input logic [WIDTH-1:0] x);
    wait_ready();
    ena      = 1'b1;
    mix_data = x;
    step();
    ena      = 1'b0;
  endtask

  task automatic write_coef(input int addr, input int val);
    wait_ready();
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = COEF_WIDTH'(val);
    step();
    coef_we    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * TAPS && exp_q.size() > 0; i++) step();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  int n0;

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b0;
    mix_data   = '0;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;

    // 1. Reset and idle
    do_reset(3);
    idle(10);
    check("idle_no_valid", valid_seen, 0);

    // 2. Impulse response with a ramp of coefficients
    for (int k = 0; k < TAPS; k++) write_coef(k, 1024 * (k + 1));
    obs_q.delete();
    for (int i = 0; i < 12; i++) begin
      push_sample((i == 0) ? 16'sd32767 : 16'sd0);
      idle(TAPS + 2);
    end
    drain();
    check("impulse_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      check("impulse_j0", {16'd0, obs_q[0]}, 32'd4096);
      check("impulse_j1", {16'd0, obs_q[1]}, 32'd8192);
      check("impulse_j2", {16'd0, obs_q[2]}, 32'd12288);
    end

    // 3. Saturation in both directions
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int i = 0; i < TAPS; i++) push_sample(16'h7fff);
    drain();
    check("sat_pos", {16'd0, fir_data}, 32'h7fff);
    for (int i = 0; i < TAPS; i++) push_sample(16'h8000);
    drain();
    check("sat_neg", {16'd0, fir_data}, 32'h8000);

    // 4. Samples dropped while busy
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 8191)) - 4096);
    for (int i = 0; i < DECIM; i++) push_sample(WIDTH'($urandom));
    n0  = ovf_seen;
    ena = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mix_data = WIDTH'($urandom);
      step();
    end
    ena = 1'b0;
    step();
    check("ovf_pulses", ovf_seen - n0, 5);
    drain();
    for (int i = 0; i < DECIM; i++) push_sample(WIDTH'($urandom));
    drain();

    // 5. Coefficient write while busy is dropped; the same write idle lands
    write_coef(0, 20000);
    for (int i = 0; i < DECIM; i++) push_sample(16'sd12000);
    idle(3);
    n0         = cerr_seen;
    coef_we    = 1'b1;
    coef_addr  = '0;
    coef_wdata = '0;
    step();
    coef_we    = 1'b0;
    step();
    check("coef_err_pulse", cerr_seen - n0, 1);
    drain();
    for (int i = 0; i < DECIM; i++) push_sample(16'sd12000);
    drain();
    write_coef(0, 0);
    for (int i = 0; i < DECIM; i++) push_sample(16'sd12000);
    drain();

    // 6. Reset in the middle of a pass
    for (int i = 0; i < DECIM; i++) push_sample(WIDTH'($urandom));
    n0 = valid_seen;
    idle(9);
    do_reset(1);
    idle(TAPS + 4);
    check("abandoned_pass", valid_seen - n0, 0);
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 8191)) - 4096);
    for (int i = 0; i < DECIM; i++) push_sample(WIDTH'($urandom));
    drain();

    // Randomised traffic: bursts of samples, drops, writes in any state
    for (int i = 0; i < 900; i++) begin
      ena        = ($urandom_range(0, 2) != 0);
      mix_data   = WIDTH'($urandom);
      coef_we    = ($urandom_range(0, 15) == 0);
      coef_addr  = AW'($urandom);
      coef_wdata = COEF_WIDTH'(int'($urandom_range(0, 8191)) - 4096);
      step();
    end
    ena     = 1'b0;
    coef_we = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
